sequential_multiplier: RTL and testbench

SEQUENTIAL_MULTIPLIER -- requirements
Module: sequential_multiplier

---
 rtl/sequential_multiplier_pkg.sv | 20 ++
 rtl/sequential_multiplier_step.sv | 23 ++
 rtl/sequential_multiplier.sv | 131 +++++++++++++
 tb/tb_sequential_multiplier.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sequential_multiplier_pkg.sv
// Shared multi-cycle ALU definitions: multiplier FSM states and latency.
package sequential_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } mult_state_e;

  localparam int unsigned MULT_BITS_DEFAULT = 32;

  // Cycles from the accepting edge to the DONE cycle: BITS steps, one sign fix-up, one DONE.
  function automatic int unsigned mult_latency(input int unsigned bits);
    return bits + 2;
  endfunction

  localparam int unsigned MULT_LATENCY = MULT_BITS_DEFAULT + 2;

endpackage

// File: rtl/sequential_multiplier_step.sv
// One radix-2 shift-add iteration on the {accumulator, multiplier} pair.
module mult_step #(
  parameter int unsigned BITS = 32
) (
  input  logic [BITS:0]   acc_i,
  input  logic [BITS-1:0] mplier_i,
  input  logic [BITS-1:0] mcand_i,
  output logic [BITS:0]   acc_o,
  output logic [BITS-1:0] mplier_o
);

  logic [BITS:0] sum;

  always_comb begin
    sum = acc_i;
    if (mplier_i[0]) begin
      sum = acc_i + {1'b0, mcand_i};
    end
    // Carry lives in sum[BITS]; it drops into the accumulator as the pair shifts right.
    {acc_o, mplier_o} = {1'b0, sum, mplier_i[BITS-1:1]};
  end

endmodule

// File: rtl/sequential_multiplier.sv
// Iterative MULT/MULTU: magnitude shift-add over BITS cycles, then a sign fix-up.
module sequential_multiplier
  import sequential_multiplier_pkg::*;
#(
  parameter int unsigned BITS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            unsign,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] hi,
  output logic [BITS-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(BITS) + 1;
  localparam int unsigned PW    = 2 * BITS;

  mult_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BITS-1:0]   mcand_q, mcand_d;
  logic [BITS:0]     acc_q, acc_d;
  logic [BITS-1:0]   mplier_q, mplier_d;
  logic              neg_q, neg_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [BITS-1:0]   hi_q, hi_d;
  logic [BITS-1:0]   lo_q, lo_d;

  logic [BITS-1:0]   a_mag, b_mag;
  logic [BITS:0]     step_acc;
  logic [BITS-1:0]   step_mplier;
  logic [PW-1:0]     prod, prod_neg;

  // -2^(BITS-1) negates to itself, which is exactly its unsigned magnitude.
  always_comb begin
    a_mag = (!unsign && a[BITS-1]) ? BITS'(-a) : a;
    b_mag = (!unsign && b[BITS-1]) ? BITS'(-b) : b;
  end

  assign prod     = {acc_q[BITS-1:0], mplier_q};
  assign prod_neg = PW'(-prod);

  mult_step #(.BITS(BITS)) u_step (
    .acc_i    (acc_q),
    .mplier_i (mplier_q),
    .mcand_i  (mcand_q),
    .acc_o    (step_acc),
    .mplier_o (step_mplier)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          cnt_d    = '0;
          mcand_d  = a_mag;
          mplier_d = b_mag;
          acc_d    = '0;
          neg_d    = !unsign && (a[BITS-1] ^ b[BITS-1]);
        end
      end
      RUN: begin
        acc_d    = step_acc;
        mplier_d = step_mplier;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BITS - 1)) begin
          state_d = SIGN;
        end
      end
      SIGN: begin
        {hi_d, lo_d} = neg_q ? prod_neg : prod;
        state_d      = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN) || (state_d == SIGN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_sequential_multiplier.sv
// Scoreboard bench for sequential_multiplier: directed products, busy/DONE starts, mid-op reset.
module tb_sequential_multiplier;
  import sequential_multiplier_pkg::*;

  localparam int unsigned BITS = 32;
  localparam int unsigned LAT  = mult_latency(BITS);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [BITS-1:0] a, b;
  logic            unsign;
  logic            busy, done;
  logic [BITS-1:0] hi, lo;

  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;

  typedef struct {
    logic [BITS-1:0] hi;
    logic [BITS-1:0] lo;
    int unsigned     done_cyc;
    string           name;
  } exp_t;

  exp_t sb[$];

  sequential_multiplier #(.BITS(BITS)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .unsign (unsign),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_hi"}, 64'(hi), 64'(e.hi));
        check({e.name, "_lo"}, 64'(lo), 64'(e.lo));
        check({e.name, "_latency"}, 64'(cyc), 64'(e.done_cyc));
      end
    end
  end

  // Accepting edge makes cyc = acc; done is seen in the cycle after edge acc+LAT-1.
  task automatic issue(input logic [BITS-1:0] av, input logic [BITS-1:0] bv, input logic u,
                       input logic [BITS-1:0] eh, input logic [BITS-1:0] el, input string name);
    exp_t e;
    @(negedge clk);
    a      = av;
    b      = bv;
    unsign = u;
    start  = 1'b1;
    e.hi = eh; e.lo = el; e.done_cyc = cyc + 1 + LAT - 1; e.name = name;
    sb.push_back(e);
    @(negedge clk);
    start  = 1'b0;
    a      = ~av;
    b      = ~bv;
    unsign = ~u;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; unsign = 1'b0;
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    issue(32'd3, 32'd5, 1'b1, 32'd0, 32'd15, "u_3x5");
    check("busy_in_run", 64'(busy), 64'd1);
    drain();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, "u_max");
    drain();
    issue(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "s_m1x1");
    drain();
    issue(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0, "s_min_sq");
    drain();
    issue(32'h8000_0000, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, "s_minx1");
    drain();
    issue(32'hFFFF_FFFD, 32'd7, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "s_m3x7");
    drain();
    repeat (3) @(negedge clk);
    check("hold_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    check("idle_busy", 64'(busy), 64'd0);
    issue(32'hFFFF_FFFD, 32'd7, 1'b1, 32'd6, 32'hFFFF_FFEB, "u_fffffffdx7");
    drain();
    issue(32'hFFFF_FFFB, 32'hFFFF_FFFA, 1'b0, 32'd0, 32'd30, "s_m5xm6");
    drain();
    issue(32'd0, 32'h8000_0000, 1'b0, 32'd0, 32'd0, "s_zero");
    drain();
    issue(32'hFFFF_FFFF, 32'd0, 1'b1, 32'd0, 32'd0, "u_zero");
    drain();

    // start with new operands while busy must be ignored
    issue(32'd3, 32'd5, 1'b1, 32'd0, 32'd15, "busy_start");
    repeat (4) @(negedge clk);
    a = 32'd9; b = 32'd9; unsign = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // start held through DONE: ignored in DONE, accepted on IDLE re-entry
    issue(32'd2, 32'd3, 1'b1, 32'd0, 32'd6, "b2b_first");
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 100);
    a = 32'd7; b = 32'd6; unsign = 1'b1; start = 1'b1;
    e.hi = 32'd0; e.lo = 32'd42; e.done_cyc = cyc + 2 + LAT - 1; e.name = "b2b_second";
    sb.push_back(e);
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    drain();

    // reset mid-operation discards the result
    issue(32'd3, 32'd5, 1'b1, 32'd0, 32'd15, "aborted");
    repeat (8) @(negedge clk);
    check("busy_before_reset", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(32'd7, 32'd6, 1'b0, 32'd0, 32'd42, "after_reset");
    drain();
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
